// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame master/slave pair: FSM states,
// nibble index constants and the field-to-nibble order.
package adc_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic [2:0] NIB_DIGIT_LO = 3'd0;
    localparam logic [2:0] NIB_DIGIT_HI = 3'd1;
    localparam logic [2:0] NIB_CUR_LO   = 3'd2;
    localparam logic [2:0] NIB_CUR_HI   = 3'd3;
    localparam logic [2:0] NIB_SET_LO   = 3'd4;
    localparam logic [2:0] NIB_SET_HI   = 3'd5;
    localparam logic [2:0] NIB_TIME     = 3'd6;
    localparam logic [2:0] NIB_LAST     = NIB_TIME;

    typedef struct packed {
        logic [7:0] digit;
        logic [7:0] cur_temp;
        logic [7:0] set_temp;
        logic [3:0] set_time;
    } frame_t;

    function automatic logic [3:0] nibble_sel(input frame_t f,
                                              input logic [2:0] idx);
        logic [3:0] n;
        n = 4'h0;
        case (idx)
            NIB_DIGIT_LO: n = f.digit[3:0];
            NIB_DIGIT_HI: n = f.digit[7:4];
            NIB_CUR_LO:   n = f.cur_temp[3:0];
            NIB_CUR_HI:   n = f.cur_temp[7:4];
            NIB_SET_LO:   n = f.set_temp[3:0];
            NIB_SET_HI:   n = f.set_temp[7:4];
            NIB_TIME:     n = f.set_time;
            default:      n = 4'h0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/adc_frame_master.sv
// Serialises a 7-nibble display/temperature frame to the ADC slave
// using a setup/strobe/gap handshake on adc_int.
module adc_frame_master
    import adc_frame_pkg::*;
#(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_HIGH  = 2,
    parameter int unsigned T_GAP   = 2,
    parameter bit          SYNC_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] digit_in,
    input  logic [7:0] cur_temp_in,
    input  logic [7:0] set_temp_in,
    input  logic [3:0] set_time_in,
    output logic       adc_int,
    output logic [3:0] data,
    output logic       slave_rst,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    localparam logic [3:0] LD_SETUP = 4'(T_SETUP - 1);
    localparam logic [3:0] LD_HIGH  = 4'(T_HIGH - 1);
    localparam logic [3:0] LD_GAP   = 4'(T_GAP - 1);

    state_t     state;
    logic [2:0] index;
    logic [3:0] timer;
    frame_t     shadow;
    frame_t     fields;
    logic       in_frame;

    assign fields = '{digit:    digit_in,
                      cur_temp: cur_temp_in,
                      set_temp: set_temp_in,
                      set_time: set_time_in};

    assign in_frame = (state == ST_SYNC) || (state == ST_SETUP) ||
                      (state == ST_STROBE) || (state == ST_GAP);

    // Outputs are registered alongside the state, so each one already
    // holds the value of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            index     <= NIB_DIGIT_LO;
            timer     <= 4'd0;
            shadow    <= '0;
            adc_int   <= 1'b0;
            data      <= 4'h0;
            slave_rst <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort && in_frame) begin
                state     <= ST_ABORT;
                adc_int   <= 1'b0;
                slave_rst <= 1'b1;
                timer     <= 4'd1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        slave_rst <= 1'b0;
                        if (start) begin
                            shadow <= fields;
                            busy   <= 1'b1;
                            index  <= NIB_DIGIT_LO;
                            if (SYNC_EN) begin
                                state     <= ST_SYNC;
                                slave_rst <= 1'b1;
                                timer     <= 4'd1;
                            end else begin
                                state <= ST_SETUP;
                                data  <= nibble_sel(fields, NIB_DIGIT_LO);
                                timer <= LD_SETUP;
                            end
                        end
                    end
                    ST_SYNC: begin
                        if (timer != 4'd0) begin
                            timer     <= timer - 4'd1;
                            slave_rst <= 1'b0;
                        end else begin
                            state <= ST_SETUP;
                            data  <= nibble_sel(shadow, index);
                            timer <= LD_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (timer != 4'd0) begin
                            timer <= timer - 4'd1;
                        end else begin
                            state   <= ST_STROBE;
                            adc_int <= 1'b1;
                            timer   <= LD_HIGH;
                        end
                    end
                    ST_STROBE: begin
                        if (timer != 4'd0) begin
                            timer <= timer - 4'd1;
                        end else begin
                            state   <= ST_GAP;
                            adc_int <= 1'b0;
                            timer   <= LD_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (timer != 4'd0) begin
                            timer <= timer - 4'd1;
                        end else if (index == NIB_LAST) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SETUP;
                            index <= index + 3'd1;
                            data  <= nibble_sel(shadow, index + 3'd1);
                            timer <= LD_SETUP;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        index <= NIB_DIGIT_LO;
                    end
                    ST_ABORT: begin
                        if (timer != 4'd0) begin
                            timer   <= timer - 4'd1;
                            aborted <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            slave_rst <= 1'b0;
                            busy      <= 1'b0;
                            index     <= NIB_DIGIT_LO;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/adc_frame_master.md
ADC_FRAME_MASTER -- requirements
Module: adc_frame_master

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Parameter T_SETUP, 1, cycles data is stable before adc_int rises (legal 1..15).
REQ-003 Parameter T_HIGH, 2, cycles adc_int is high (legal 1..15).
REQ-004 Parameter T_GAP, 2, cycles adc_int is low after a strobe (legal 1..15).
REQ-005 Parameter SYNC_EN, 1, 1 = pulse slave_rst before every frame.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  frame request, sampled only in IDLE.
REQ-009 abort  in  1  cancel frame in progress.
REQ-010 digit_in  in  8  display digit code.
REQ-011 cur_temp_in  in  8  current temperature.
REQ-012 set_temp_in  in  8  setpoint temperature.
REQ-013 set_time_in  in  4  set time.
REQ-014 adc_int  out  1  nibble strobe to slave, rising edge = capture.
REQ-015 data  out  4  nibble bus to slave.
REQ-016 slave_rst  out  1  active-high resync of slave frame counter.
REQ-017 busy  out  1  high from the cycle after accepted start until the return to IDLE.
REQ-018 done  out  1  one-cycle pulse, frame completed.
REQ-019 aborted  out  1  one-cycle pulse, frame cancelled.

Function
REQ-020 All outputs SHALL be registered; adc_int and slave_rst glitch-free.
REQ-021 Frame = 7 nibbles, index 0..6: digit[3:0], digit[7:4], cur_temp[3:0], cur_temp[7:4], set_temp[3:0], set_temp[7:4], set_time.
REQ-022 start in IDLE SHALL latch all four field inputs into shadow registers; field changes during a frame have no effect.
REQ-023 States: IDLE, SYNC, SETUP, STROBE, GAP, DONE, ABORT.
REQ-024 IDLE -> SYNC on start when SYNC_EN=1, else IDLE -> SETUP; start while busy is ignored (not queued).
REQ-025 SYNC: 2 cycles, slave_rst=1 in first, 0 in second, then SETUP with index 0.
REQ-026 SETUP: data=nibble[index], adc_int=0, T_SETUP cycles, then STROBE.
REQ-027 STROBE: adc_int=1, data held, T_HIGH cycles, then GAP.
REQ-028 GAP: adc_int=0, data held, T_GAP cycles; index 6 -> DONE, else index+1 -> SETUP.
REQ-029 DONE: done=1 for 1 cycle, busy=0 next, -> IDLE; data keeps last nibble.
REQ-030 Frame length from start-sample edge to done = 2*SYNC_EN + 7*(T_SETUP+T_HIGH+T_GAP) + 1 cycles (defaults: 38).
REQ-031 Phase timer 4-bit down-counter loaded on state entry; index 3-bit, never exceeds 6.
REQ-032 abort in SYNC/SETUP/STROBE/GAP -> ABORT next cycle: adc_int=0, slave_rst=1 for 2 cycles, aborted=1 on last ABORT cycle, -> IDLE; no done.
REQ-033 abort in IDLE or DONE ignored; abort and start together in IDLE -> start wins.
REQ-034 abort in the same cycle as the last GAP cycle of index 6 -> abort wins, no done.

Reset
REQ-035 rst_n low: state IDLE, index 0, timer 0, adc_int 0, data 0, busy 0, done 0, aborted 0, slave_rst 1.
REQ-036 slave_rst SHALL clear on the first clock edge after rst_n release; reset mid-frame drops the frame, no done.

Structure
REQ-037 State encoding, nibble-index constants (0..6, LAST=6) and field-to-nibble order SHALL live in the shared macros/package file used by the ADC slave.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Defaults, start with digit=0x3A, cur=0x5C, set=0x96, time=0x7 -> slave captures nibbles A,3,C,5,6,9,7; done at cycle 38.
REQ-040 SYNC_EN=0, T_SETUP=T_HIGH=T_GAP=1 -> done at cycle 22, no slave_rst pulse.
REQ-041 Inputs changed to 0xFF mid-frame -> transmitted frame unchanged; start pulses while busy -> exactly one frame.
REQ-042 abort during nibble 3 STROBE -> adc_int low next cycle, slave_rst high 2 cycles, aborted pulse, no done; next frame captures correctly.
REQ-043 rst_n low mid-frame -> all outputs at reset values asynchronously, slave_rst=1, clears one edge after release.
REQ-044 abort coincident with final GAP cycle -> aborted=1, done never asserted.
